// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Captures the MEM-stage instruction into write-back registers. Sub-word loads
// are aligned and extended before capture, so WB_data is ready for the register
// file. Also keeps counts of retired instructions and bubbles.
module mem_wb_reg #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             RegWrite,
  input  logic             MemToReg,
  input  logic [1:0]       LoadSize,
  input  logic             LoadSigned,
  input  logic [31:0]      alu_out,
  input  logic [31:0]      douta,
  input  logic [4:0]       RegMux,
  input  logic             cnt_clr,
  output logic             WB_valid,
  output logic             WB_RegWrite,
  output logic [4:0]       WB_RegMux,
  output logic [31:0]      WB_data,
  output logic [31:0]      MEM_WB_alu_out,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [15:0]      bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      BUB_MAX = 16'hFFFF;

  logic        capture;
  logic        wr_en;
  logic        bub_inc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] wb_src;

  // A capture is a normal pipeline advance; flush overrides stall.
  assign capture = !flush && !stall;

  // Register 0 is hard-wired to zero, so a write to it is dropped here.
  assign wr_en = RegWrite && in_valid && (RegMux != 5'd0);

  // Every flush edge inserts a bubble, as does an advance of a non-valid slot.
  assign bub_inc = flush || (capture && !in_valid);

  // Load alignment: pick the addressed byte/halfword and extend it.
  always_comb begin
    ld_byte   = douta[7:0];
    ld_half   = douta[15:0];
    load_data = douta;
    case (alu_out[1:0])
      2'b00:   ld_byte = douta[7:0];
      2'b01:   ld_byte = douta[15:8];
      2'b10:   ld_byte = douta[23:16];
      default: ld_byte = douta[31:24];
    endcase
    // alu_out[0] is ignored for halfwords; misaligned access just truncates.
    ld_half = alu_out[1] ? douta[31:16] : douta[15:0];
    case (LoadSize)
      2'b00:   load_data = LoadSigned ? {{24{ld_byte[7]}}, ld_byte}
                                      : {24'd0, ld_byte};
      2'b01:   load_data = LoadSigned ? {{16{ld_half[15]}}, ld_half}
                                      : {16'd0, ld_half};
      default: load_data = douta;
    endcase
  end

  assign wb_src = MemToReg ? load_data : alu_out;

  // Pipeline register: flush loads a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_valid       <= 1'b0;
      WB_RegWrite    <= 1'b0;
      WB_RegMux      <= 5'd0;
      WB_data        <= 32'd0;
      MEM_WB_alu_out <= 32'd0;
    end else if (flush) begin
      WB_valid       <= 1'b0;
      WB_RegWrite    <= 1'b0;
      WB_RegMux      <= 5'd0;
      WB_data        <= 32'd0;
      MEM_WB_alu_out <= 32'd0;
    end else if (!stall) begin
      WB_valid       <= in_valid;
      WB_RegWrite    <= wr_en;
      WB_RegMux      <= RegMux;
      WB_data        <= wb_src;
      MEM_WB_alu_out <= alu_out;
    end
  end

  // Retired-instruction counter; wraps naturally, clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (cnt_clr) begin
      retire_cnt <= '0;
    end else if (capture && in_valid) begin
      retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

  // Bubble counter; saturates at all-ones, clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 16'd0;
    end else if (cnt_clr) begin
      bubble_cnt <= 16'd0;
    end else if (bub_inc && (bubble_cnt != BUB_MAX)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, in_valid, RegWrite, MemToReg, LoadSigned, cnt_clr;
  logic [1:0]    LoadSize;
  logic [31:0]   alu_out, douta;
  logic [4:0]    RegMux;
  logic          WB_valid, WB_RegWrite;
  logic [4:0]    WB_RegMux;
  logic [31:0]   WB_data, MEM_WB_alu_out;
  logic [CW-1:0] retire_cnt;
  logic [15:0]   bubble_cnt;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int exp_bub = 0;

  mem_wb_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .LoadSize(LoadSize),
    .LoadSigned(LoadSigned), .alu_out(alu_out), .douta(douta), .RegMux(RegMux),
    .cnt_clr(cnt_clr), .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite),
    .WB_RegMux(WB_RegMux), .WB_data(WB_data), .MEM_WB_alu_out(MEM_WB_alu_out),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic rw, input logic m2r, input logic [1:0] ls,
                     input logic lsg, input logic [31:0] a, input logic [31:0] d,
                     input logic [4:0] rd);
    in_valid = v; RegWrite = rw; MemToReg = m2r; LoadSize = ls;
    LoadSigned = lsg; alu_out = a; douta = d; RegMux = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_ret"}, {28'd0, retire_cnt}, exp_ret % 16);
    chk({tag, "_bub"}, {16'd0, bubble_cnt}, exp_bub);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, WB_valid}, 32'd0);
    chk({tag, "_rw"}, {31'd0, WB_RegWrite}, 32'd0);
    chk({tag, "_rd"}, {27'd0, WB_RegMux}, 32'd0);
    chk({tag, "_data"}, WB_data, 32'd0);
    chk({tag, "_alu"}, MEM_WB_alu_out, 32'd0);
    chk({tag, "_ret"}, {28'd0, retire_cnt}, 32'd0);
    chk({tag, "_bub"}, {16'd0, bubble_cnt}, 32'd0);
  endtask

  // One captured load/ALU vector with its hand-computed write-back data.
  task automatic cap(input string tag, input logic m2r, input logic [1:0] ls, input logic lsg,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_data);
    drv(1'b1, 1'b1, m2r, ls, lsg, a, d, 5'd9);
    tick;
    exp_ret++;
    chk({tag, "_data"}, WB_data, exp_data);
    chk({tag, "_alu"}, MEM_WB_alu_out, a);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drv(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h1234, 32'hDEADBEEF, 5'd3);
    #2;
    chk_zero("reset");
    tick; tick;
    chk_zero("reset_edges");
    #2 rst_n = 1'b1;

    // Signed byte load
    drv(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 32'h103, 32'h80FF1234, 5'd5);
    tick; exp_ret++;
    chk("sb_data", WB_data, 32'hFFFFFF80);
    chk("sb_rd", {27'd0, WB_RegMux}, 32'd5);
    chk("sb_rw", {31'd0, WB_RegWrite}, 32'd1);
    chk("sb_valid", {31'd0, WB_valid}, 32'd1);
    chk_cnt("sb");

    cap("lhu",   1'b1, 2'b01, 1'b0, 32'h102, 32'h8001ABCD, 32'h00008001);
    cap("lh",    1'b1, 2'b01, 1'b1, 32'h102, 32'h8001ABCD, 32'hFFFF8001);
    cap("lbu0",  1'b1, 2'b00, 1'b0, 32'h100, 32'h80FF1234, 32'h00000034);
    cap("lb1",   1'b1, 2'b00, 1'b1, 32'h101, 32'h80FF1234, 32'h00000012);
    cap("lbu2",  1'b1, 2'b00, 1'b0, 32'h102, 32'h80FF1234, 32'h000000FF);
    cap("lh_odd",1'b1, 2'b01, 1'b1, 32'h101, 32'h8001ABCD, 32'hFFFFABCD);
    cap("lw11",  1'b1, 2'b11, 1'b1, 32'h103, 32'h8001ABCD, 32'h8001ABCD);
    cap("lw10",  1'b1, 2'b10, 1'b0, 32'h102, 32'h00C0FFEE, 32'h00C0FFEE);
    cap("alu",   1'b0, 2'b00, 1'b1, 32'h55,  32'h80FF1234, 32'h00000055);
    chk_cnt("alu");

    // Stall three cycles while inputs change
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hA0 + i, 32'd0, 5'd20 + 5'(i));
      tick;
      chk("stall_data", WB_data, 32'h55);
      chk("stall_rd", {27'd0, WB_RegMux}, 32'd9);
      chk_cnt("stall");
    end
    flush = 1'b1;
    tick; exp_bub++;
    chk("flush_valid", {31'd0, WB_valid}, 32'd0);
    chk("flush_data", WB_data, 32'd0);
    chk("flush_alu", MEM_WB_alu_out, 32'd0);
    chk("flush_rd", {27'd0, WB_RegMux}, 32'd0);
    chk_cnt("flush");
    flush = 1'b0; stall = 1'b0;

    // Register 0 write suppressed, still retires
    drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h77, 32'd0, 5'd0);
    tick; exp_ret++;
    chk("r0_rw", {31'd0, WB_RegWrite}, 32'd0);
    chk("r0_data", WB_data, 32'h77);
    chk_cnt("r0");

    // Non-valid capture is a bubble and never writes
    drv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h88, 32'd0, 5'd4);
    tick; exp_bub++;
    chk("inv_rw", {31'd0, WB_RegWrite}, 32'd0);
    chk("inv_valid", {31'd0, WB_valid}, 32'd0);
    chk_cnt("inv");

    // Clear with a simultaneous valid capture
    cnt_clr = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h99, 32'd0, 5'd6);
    tick; exp_ret = 0; exp_bub = 0;
    cnt_clr = 1'b0;
    chk("clr_data", WB_data, 32'h99);
    chk("clr_rw", {31'd0, WB_RegWrite}, 32'd1);
    chk_cnt("clr");

    // Retire counter wrap with 4-bit width
    for (int i = 0; i < 17; i++) tick;
    exp_ret = 17;
    chk_cnt("wrap");

    // Bubble counter saturation
    flush = 1'b1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1; exp_bub = 16'hFFFF;
    chk_cnt("bub_full");
    flush = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'd0, 5'd0);
    tick;
    chk_cnt("bub_sat");

    cnt_clr = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h42, 32'd0, 5'd7);
    tick; exp_ret = 0; exp_bub = 0;
    cnt_clr = 1'b0;
    chk_cnt("clr2");

    // Asynchronous reset mid-stream, with stall active
    drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1111, 32'd0, 5'd8);
    tick; exp_ret++;
    chk("pre_rst_data", WB_data, 32'h1111);
    #2 rst_n = 1'b0; stall = 1'b1;
    #1;
    chk_zero("arst");
    tick; tick;
    chk_zero("arst_hold");
    #2 rst_n = 1'b1; stall = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h2222, 32'd0, 5'd10);
    tick;
    chk("post_rst_data", WB_data, 32'h2222);
    chk("post_rst_rd", {27'd0, WB_RegMux}, 32'd10);
    exp_ret = 1; exp_bub = 0;
    chk_cnt("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with the following ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the MEM/WB contents this cycle.
- flush  in  1  replace the captured instruction with a bubble.
- in_valid  in  1  the MEM-stage instruction is real, not a bubble.
- RegWrite  in  1  the MEM-stage instruction writes the register file.
- MemToReg  in  1  write-back source: 1 selects load data, 0 selects alu_out.
- LoadSize  in  2  load size: 00 byte, 01 halfword, 10 or 11 word.
- LoadSigned  in  1  1 sign-extends sub-word loads, 0 zero-extends them.
- alu_out  in  32  MEM-stage ALU result; this is also the byte address for loads.
- douta  in  32  word read from data memory; it is 0 when no read occurs.
- RegMux  in  5  destination register number.
- cnt_clr  in  1  synchronous clear of both counters.
- WB_valid  out  1  registered copy of in_valid.
- WB_RegWrite  out  1  register-file write enable.
- WB_RegMux  out  5  write-back destination register.
- WB_data  out  32  write-back data.
- MEM_WB_alu_out  out  32  registered alu_out; this is the forwarding source for MEM-stage store data.
- retire_cnt  out  CNT_W  count of retired instructions.
- bubble_cnt  out  16  count of bubbles, saturating.

Function
REQ-003 Every output SHALL be a register output; the block SHALL contain no combinational input-to-output path.
REQ-004 A capture SHALL be a rising edge with flush=0 and stall=0; at a capture all WB_* registers SHALL load from the inputs, so latency is exactly one cycle.
REQ-005 When flush=1 at a rising edge, the block SHALL load a bubble: WB_valid=0, WB_RegWrite=0, WB_RegMux=0, WB_data=0, MEM_WB_alu_out=0; flush SHALL take priority over stall.
REQ-006 When stall=1 and flush=0 at a rising edge, every WB_* register and MEM_WB_alu_out SHALL hold its value.
REQ-007 At a capture, WB_RegWrite SHALL load RegWrite AND in_valid AND (RegMux != 0); writes to register 0 are always suppressed.
REQ-008 At a capture with MemToReg=0, WB_data SHALL load alu_out.
REQ-009 At a capture with MemToReg=1 and LoadSize=00, WB_data SHALL load douta byte alu_out[1:0], where byte k is bits 8k+7 to 8k, extended to 32 bits per LoadSigned.
REQ-010 At a capture with MemToReg=1 and LoadSize=01, WB_data SHALL load the douta halfword selected by alu_out[1] (1 selects bits 31:16, 0 selects bits 15:0), extended per LoadSigned; alu_out[0] is ignored, and no misalignment trap exists.
REQ-011 At a capture with MemToReg=1 and LoadSize of 10 or 11, WB_data SHALL load douta unchanged; alu_out[1:0] and LoadSigned are ignored.
REQ-012 retire_cnt SHALL increment by 1 at each capture with in_valid=1, and SHALL wrap from all-ones to 0.
REQ-013 bubble_cnt SHALL increment by 1 at each capture with in_valid=0 and at each edge with flush=1; it SHALL saturate at 16'hFFFF.
REQ-014 A stalled edge SHALL change neither counter.
REQ-015 cnt_clr=1 at a rising edge SHALL load both counters with 0, taking priority over any simultaneous increment; it SHALL not affect the WB_* registers.
REQ-016 Inputs while stall=1 SHALL have no effect; the instruction present when stall deasserts is the one captured.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, force all outputs and both counters to 0.
REQ-018 While rst_n=0, clk edges SHALL have no effect.
REQ-019 On the first rising edge after rst_n rises, the block SHALL operate normally.
REQ-020 Reset asserted while stall or flush is active SHALL still clear everything; no state survives reset.

Verification
REQ-021 Signed byte load: in_valid=1, RegWrite=1, MemToReg=1, LoadSize=00, LoadSigned=1, alu_out=0x103, douta=0x80FF1234, RegMux=5 -> next cycle WB_data=0xFFFFFF80, WB_RegMux=5, WB_RegWrite=1, retire_cnt=1.
REQ-022 Halfword load: LoadSize=01, LoadSigned=0, alu_out=0x102, douta=0x8001ABCD -> WB_data=0x00008001; repeat with LoadSigned=1 -> WB_data=0xFFFF8001.
REQ-023 Stall and flush: capture alu_out=0x55 (MemToReg=0); hold stall=1 for 3 cycles while inputs change -> WB_data stays 0x55 and counters are unchanged; then assert flush=1 with stall=1 -> WB_valid=0, WB_data=0, bubble_cnt+1.
REQ-024 Register-0 write: RegWrite=1, in_valid=1, RegMux=0 -> WB_RegWrite=0 while retire_cnt still increments.
REQ-025 Counter limits: with CNT_W=4, retire 17 valid instructions -> retire_cnt=1; preload bubble_cnt to 0xFFFF, add one bubble -> 0xFFFF; assert cnt_clr together with a valid capture -> both counters 0.
REQ-026 Asynchronous reset: drive rst_n low between clock edges mid-stream -> all outputs read 0 before the next edge and stay 0 through 2 edges while rst_n=0.
